// File: rtl/serial_word_rx_pkg.sv
// rtl/serial_word_rx_pkg.sv - shared types and constants for the serial word receiver
package serial_word_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_receiver.sv
// rtl/serial_word_receiver.sv - serial-to-word receiver with valid/ready output register
// Optional trailing even-parity bit and m_perr output enabled by PARITY_CHECK_EN.
module serial_word_receiver
  import serial_word_rx_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_bit,
  input  logic             s_valid,
  input  logic             s_dir,
  input  logic             sync,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
`ifdef PARITY_CHECK_EN
  output logic             m_perr,
`endif
  output logic             overrun
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  rx_state_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shift_val, word_val;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             dir_q, dir_d, dir_eff;
  logic             word_done;
`ifdef PARITY_CHECK_EN
  logic             word_perr;
`endif

  // The first bit of a word uses the live s_dir; later bits use the latched one.
  assign dir_eff   = (state_q == IDLE) ? s_dir : dir_q;
  assign shift_val = (dir_eff == DIR_LSB_FIRST) ? {s_bit, shreg_q[WIDTH-1:1]}
                                                : {shreg_q[WIDTH-2:0], s_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      dir_q     <= DIR_MSB_FIRST;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    dir_d     = dir_q;
    word_done = 1'b0;
    word_val  = shift_val;
`ifdef PARITY_CHECK_EN
    word_perr = 1'b0;
`endif
    if (sync) begin
      state_d   = IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
    end else if (s_valid) begin
      case (state_q)
        IDLE: begin
          dir_d     = s_dir;
          shreg_d   = shift_val;
          bit_cnt_d = CNT_W'(1);
          state_d   = SHIFT;
        end
        SHIFT: begin
          shreg_d = shift_val;
          if (bit_cnt_q == LAST_IDX) begin
`ifdef PARITY_CHECK_EN
            bit_cnt_d = CNT_W'(WIDTH);
            state_d   = PARITY;
`else
            word_done = 1'b1;
            shreg_d   = '0;
            bit_cnt_d = '0;
            state_d   = IDLE;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
`ifdef PARITY_CHECK_EN
        PARITY: begin
          // s_bit here is the even-parity bit over the completed word.
          word_done = 1'b1;
          word_val  = shreg_q;
          word_perr = ^{shreg_q, s_bit};
          shreg_d   = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
`endif
        default: begin
          shreg_d   = '0;
          bit_cnt_d = '0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  // Output holding register: a completing word either loads or is dropped as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data  <= '0;
      m_valid <= 1'b0;
      overrun <= 1'b0;
`ifdef PARITY_CHECK_EN
      m_perr  <= 1'b0;
`endif
    end else if (word_done) begin
      if (!m_valid || m_ready) begin
        m_data  <= word_val;
        m_valid <= 1'b1;
`ifdef PARITY_CHECK_EN
        m_perr  <= word_perr;
`endif
      end else begin
        overrun <= 1'b1;
      end
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule
